// File: rtl/loader_pkg.sv
// Shared types and helpers for the instruction memory loader.
// The fetch side defines its byte order against byte_of(), so both ends
// of the instruction memory agree on big-endian packing.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Big-endian byte select: index 0 is the most significant byte.
    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/instruction_memory_loader.sv
// Writer-side loader for the byte-addressed, big-endian instruction memory.
// Accepts 32-bit words over valid/ready and writes each one as four bytes,
// most significant byte at the lowest address. busy stalls the CPU while a
// program is being loaded; done/error report how the session ended.
// BASE_ADDR must be a multiple of 4 and BASE_ADDR + 4*MAX_WORDS must fit
// in the ADDR_WIDTH byte address space.
module instruction_memory_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 4096,
    localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [31:0]           i_word_in,
    input  logic                  i_word_valid,
    input  logic                  i_word_last,
    output logic                  o_word_ready,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [7:0]            o_mem_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [CNT_W-1:0]      o_word_count
);

    state_t           r_state;
    logic [CNT_W-1:0] r_word_count;
    logic [1:0]       r_byte_idx;
    logic [31:0]      r_word;
    logic             r_last;
    logic             r_done;
    logic             r_error;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_word_count_next;
    logic [1:0]       w_byte_idx_next;
    logic [31:0]      w_word_next;
    logic             w_last_next;
    logic             w_done_next;
    logic             w_error_next;

    logic [CNT_W-1:0]      w_count_inc;
    logic [ADDR_WIDTH-1:0] w_byte_addr;

    assign w_count_inc = r_word_count + CNT_W'(1);

    // State and datapath registers; reset returns to IDLE with everything cleared.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (i_reset) begin
            r_state      <= IDLE;
            r_word_count <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_last       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_word_count <= w_word_count_next;
            r_byte_idx   <= w_byte_idx_next;
            r_word       <= w_word_next;
            r_last       <= w_last_next;
            r_done       <= w_done_next;
            r_error      <= w_error_next;
        end
    end

    // Next-state logic: session start, word capture, byte sequencing and completion.
    always_comb begin
        // NOTE: every next value defaults to its register so no latch is inferred.
        w_state_next      = r_state;
        w_word_count_next = r_word_count;
        w_byte_idx_next   = r_byte_idx;
        w_word_next       = r_word;
        w_last_next       = r_last;
        w_done_next       = r_done;
        w_error_next      = r_error;

        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_state_next      = WAIT_WORD;
                    w_word_count_next = '0;
                    w_done_next       = 1'b0;
                    w_error_next      = 1'b0;
                end
            end
            WAIT_WORD: begin
                // word_ready is high throughout this state, so valid alone completes the handshake.
                if (i_word_valid) begin
                    w_word_next     = i_word_in;
                    w_last_next     = i_word_last;
                    w_byte_idx_next = '0;
                    w_state_next    = WRITE;
                end
            end
            WRITE: begin
                w_byte_idx_next = r_byte_idx + 2'd1;
                if (r_byte_idx == 2'(BYTES_PER_WORD - 1)) begin
                    w_word_count_next = w_count_inc;
                    if (r_last) begin
                        w_state_next = DONE;
                        w_done_next  = 1'b1;
                    end else if (w_count_inc == CNT_W'(MAX_WORDS)) begin
                        // Capacity reached without a last word: end the session as an overflow.
                        w_state_next = DONE;
                        w_done_next  = 1'b1;
                        w_error_next = 1'b1;
                    end else begin
                        w_state_next = WAIT_WORD;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Byte address of the current write; wraps within the ADDR_WIDTH space.
    assign w_byte_addr = ADDR_WIDTH'(BASE_ADDR)
                       + (ADDR_WIDTH'(r_word_count) << 2)
                       + ADDR_WIDTH'(r_byte_idx);

    // Outputs decode registers only; address and data are zeroed outside WRITE.
    assign o_word_ready = (r_state == WAIT_WORD);
    assign o_busy       = (r_state == WAIT_WORD) || (r_state == WRITE);
    assign o_mem_we     = (r_state == WRITE);
    assign o_mem_addr   = o_mem_we ? w_byte_addr : '0;
    assign o_mem_wdata  = o_mem_we ? byte_of(r_word, r_byte_idx) : 8'h00;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_word_count = r_word_count;

endmodule

// File: doc/instruction_memory_loader.md
Name: instruction_memory_loader

Overview:
Writer-side companion to the byte-addressed, big-endian instruction memory.
- Accepts 32-bit program words over a valid/ready handshake.
- Serialises each word into four byte writes on the memory write port: MSB at the lowest address, so a later 4-byte fetch at PC returns the original word.
- Sits between the boot/host link and the instruction memory write port.
- busy holds the CPU in stall while a program is being loaded.

Parameters:
- ADDR_WIDTH, 14, byte address width of the instruction memory.
- BASE_ADDR, 0, byte address of the first loaded word; must be a multiple of 4.
- MAX_WORDS, 4096, capacity in words. BASE_ADDR + 4*MAX_WORDS must be <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load session; sampled only in IDLE or DONE.
- word_in  in  32  program word.
- word_valid  in  1  word_in (and last) valid.
- word_last  in  1  qualifies word_in as the final word of the program.
- word_ready  out  1  loader can accept a word this cycle.
- mem_we  out  1  byte write enable to instruction memory.
- mem_addr  out  ADDR_WIDTH  byte write address.
- mem_wdata  out  8  byte write data.
- busy  out  1  session in progress (IDLE and DONE excluded).
- done  out  1  session finished; level, held until next start or reset.
- error  out  1  capacity overflow; level, held with done.
- word_count  out  ceil(log2(MAX_WORDS+1))  words fully written in current/last session.

Behaviour:
Reset and output timing:
- reset (synchronous, active-high) -> state IDLE; all outputs 0; word_count 0; byte index 0; captured word 0.
- All outputs are decoded from registers only; there is no combinational path from inputs to outputs.

States: IDLE, WAIT_WORD, WRITE, DONE.
- IDLE: word_ready=0, mem_we=0. start=1 -> WAIT_WORD; word_count<=0; done<=0; error<=0.
- WAIT_WORD: word_ready=1, busy=1. When word_valid & word_ready, capture word_in and word_last, byte_idx<=0, go to WRITE. word_valid=0 -> stay; no timeout.
- WRITE: busy=1, word_ready=0, mem_we=1 every cycle.
  - mem_addr = BASE_ADDR + 4*word_count + byte_idx, truncated to ADDR_WIDTH.
  - mem_wdata by byte_idx: 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - byte_idx increments each cycle.
  - On byte_idx=3: word_count<=word_count+1, then:
    - if last_reg -> DONE, error stays 0.
    - else if word_count+1 == MAX_WORDS -> DONE with error<=1.
    - else -> WAIT_WORD.
- DONE: done=1, busy=0, word_ready=0, mem_we=0. start=1 -> same actions as start from IDLE.

Timing:
- Handshake in cycle N -> byte writes in cycles N+1..N+4 -> word_ready=1 again in cycle N+5.
- Throughput: one word per 5 cycles.

Boundary rules:
- start while busy: ignored.
- word_valid in IDLE/DONE/WRITE: not accepted; the producer must hold the word until ready.
- word_last on word number MAX_WORDS: normal completion, error=0.
- Overflow: the session ends at capacity with error=1; extra words are never accepted.
- Reset mid-WRITE: takes priority. mem_we=0 from the following cycle; the partial word is abandoned, and bytes already written stay in memory.
- The loader never reads memory; the fetch port is unaffected.

Decomposition:
- Shared package loader_pkg:
  - state enum {IDLE, WAIT_WORD, WRITE, DONE};
  - BYTES_PER_WORD=4;
  - function byte_of(word, idx), big-endian select; the fetch-side byte order is defined against this function.
- No sub-module: the FSM, counters and byte mux are a single flat module (~150-200 lines).

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> all outputs 0. word_valid=1 without start -> word_ready stays 0, no mem_we.
- Single word with last: start; word_in=32'hDEADBEEF, word_last=1 -> writes (0,DE),(1,AD),(2,BE),(3,EF) in consecutive cycles; then done=1, error=0, word_count=1.
- Three words, valid held high: 32'h11223344, 32'h55667788, 32'h99AABBCC (last on third) -> 12 writes at addresses 0..11 in big-endian order. word_ready pulses exactly once per 5 cycles; word_count=3; reading back via the fetch path returns the same words.
- Overflow with MAX_WORDS=2, BASE_ADDR=16: 3 words offered, no last -> writes to addresses 16..23 only; done=1, error=1, third word never accepted.
- Reset mid-WRITE after the 2nd byte of word 32'hCAFEF00D -> mem_we=0 the next cycle; only addresses 0,1 hold CA,FE; state IDLE; word_count=0.
- Restart from DONE: second start then one word 32'h01020304 with last -> done/error clear on start; writes to addresses 0..3; word_count=1.
